layer_1_maxpool2x2: RTL

Streaming 2x2, stride-2 max-pooling stage for YOLOv3-Tiny layer 1. It consumes one raster-ordered IEEE-754 single-precision feature map from a layer-0 feature-map block (`data_out`/`valid_out`) and emits one pooled pixel per 2x2 window. The output is an (IMG_SIZE/2)x(IMG_SIZE/2) map in raster order, which feeds the layer-2 convolution. One instance is used per feature map.

---
 rtl/layer_1_maxpool2x2_pkg.sv | 11 +
 rtl/layer_1_maxpool2x2_if.sv | 30 +++
 rtl/layer_1_maxpool2x2_fp32_max.sv | 29 ++
 rtl/layer_1_maxpool2x2.sv | 110 +++++++++++
 4 files changed

// File: rtl/layer_1_maxpool2x2_pkg.sv
// Shared YOLO datapath types: binary32 pixel type and signed-zero constants.
package yolo_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] fp32_t;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/layer_1_maxpool2x2_if.sv
// Pixel stream bundle for the max-pool stage.
//   data_in/valid_in            : raster-ordered input pixels (no backpressure)
//   data_out/valid_out/frame_end: pooled pixel, one-cycle strobe, last-of-frame flag
// master drives the input side; slave is the pooling block.
interface layer_1_maxpool2x2_if;
    import yolo_pkg::*;

    fp32_t data_in;
    logic  valid_in;
    fp32_t data_out;
    logic  valid_out;
    logic  frame_end;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out,
        input  frame_end
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out,
        output frame_end
    );

endinterface

// File: rtl/layer_1_maxpool2x2_fp32_max.sv
// Combinational binary32 max on raw bits, treated as a total order:
// sign-magnitude compare, +0 above -0, NaNs ordered like any other pattern.
//   a, b : operands (a is returned on a tie)
//   y_c  : the larger operand
module fp32_max
    import yolo_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y_c
);

    logic b_gt_a_c;

    always_comb begin
        b_gt_a_c = 1'b0;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            // differing signs: the positive operand wins
            b_gt_a_c = a[DATA_WIDTH-1];
        end else if (a[DATA_WIDTH-1]) begin
            // both negative: smaller magnitude is larger
            b_gt_a_c = (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]);
        end else begin
            b_gt_a_c = (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]);
        end
        y_c = b_gt_a_c ? b : a;
    end

endmodule

// File: rtl/layer_1_maxpool2x2.sv
// Streaming 2x2 stride-2 max-pool over a raster IMG_SIZE x IMG_SIZE binary32 map.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows fold
// their horizontal pair with the buffered one and emit one pooled pixel.
//   Clk : clock (rising edge)
//   Rst : asynchronous active-low reset
//   bus : slave side of the pixel stream bundle
module layer_1_maxpool2x2
    import yolo_pkg::*;
#(
    parameter int unsigned IMG_SIZE = 416
) (
    input  logic                 Clk,
    input  logic                 Rst,
    layer_1_maxpool2x2_if.slave  bus
);

    localparam int unsigned CW   = $clog2(IMG_SIZE);
    localparam int unsigned HALF = IMG_SIZE / 2;
    localparam int unsigned AW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    fp32_t         hold;
    fp32_t         rd_q;
    fp32_t         hmax_c;
    fp32_t         vmax_c;
    fp32_t         linebuf [HALF];

    logic          col_last_c;
    logic          row_last_c;
    logic [AW-1:0] addr_c;
    logic          wr_c;
    logic          rd_c;
    logic          win_c;

    // Beat classification from the raster position
    always_comb begin
        col_last_c = (col == CW'(IMG_SIZE - 1));
        row_last_c = (row == CW'(IMG_SIZE - 1));
        addr_c     = AW'(col >> 1);
        wr_c       = bus.valid_in && !row[0] &&  col[0];
        rd_c       = bus.valid_in &&  row[0] && !col[0];
        win_c      = bus.valid_in &&  row[0] &&  col[0];
    end

    fp32_t vmax_in_c;
    assign vmax_in_c = hmax_c;

    fp32_max u_hmax (
        .a   (hold),
        .b   (bus.data_in),
        .y_c (hmax_c)
    );

    fp32_max u_vmax (
        .a   (vmax_in_c),
        .b   (rd_q),
        .y_c (vmax_c)
    );

    // Raster position counters; frames run back-to-back
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.valid_in) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Left pixel of each horizontal pair
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hold <= FP32_POS_ZERO;
        end else if (bus.valid_in && !col[0]) begin
            hold <= bus.data_in;
        end
    end

    // Single-port line buffer; read data stays put across input gaps
    always_ff @(posedge Clk) begin
        if (wr_c) begin
            linebuf[addr_c] <= hmax_c;
        end
        if (rd_c) begin
            rd_q <= linebuf[addr_c];
        end
    end

    // Registered pooled output
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bus.data_out  <= FP32_POS_ZERO;
            bus.valid_out <= 1'b0;
            bus.frame_end <= 1'b0;
        end else begin
            bus.valid_out <= win_c;
            bus.frame_end <= win_c && row_last_c && col_last_c;
            if (win_c) begin
                bus.data_out <= vmax_c;
            end
        end
    end

endmodule
